// File: rtl/fpnew_rounding_pipe.sv
// Multi-lane IEEE-754 rounding back-end.
// Each lane applies one rounding increment to a pre-rounded magnitude.
// The packed lane results plus a tag then travel through NumPipeRegs
// valid/ready register stages.

// Single-lane rounding: decides the increment, applies it, derives flags.
module fpnew_rounding_lane #(
    parameter int unsigned AbsWidth = 8
) (
    input  logic [AbsWidth-1:0] abs_value,
    input  logic                sign,
    input  logic [1:0]          round_sticky,
    input  logic [2:0]          rnd_mode,
    input  logic                effective_subtraction,
    input  logic                lane_en,
    output logic [AbsWidth-1:0] abs_rounded,
    output logic                sign_res,
    output logic                exact_zero,
    output logic                inexact,
    output logic                carry
);
    logic                round_up;
    logic [AbsWidth:0]   sum;
    logic                zero_raw;
    logic                sign_raw;

    // Rounding decision per mode; reserved encodings truncate
    always_comb begin
        round_up = 1'b0;
        case (rnd_mode)
            3'b000: begin
                case (round_sticky)
                    2'b10:   round_up = abs_value[0];
                    2'b11:   round_up = 1'b1;
                    default: round_up = 1'b0;
                endcase
            end
            3'b001:  round_up = 1'b0;
            3'b010:  round_up = (|round_sticky) & sign;
            3'b011:  round_up = (|round_sticky) & ~sign;
            3'b100:  round_up = round_sticky[1];
            3'b101:  round_up = ~abs_value[0] & (|round_sticky);
            default: round_up = 1'b0;
        endcase
    end

    // One bit wider so an all-ones magnitude wraps to zero with carry set
    assign sum      = {1'b0, abs_value} + {{AbsWidth{1'b0}}, round_up};
    assign zero_raw = (abs_value == '0) && (round_sticky == 2'b00);
    // Exact zero of an effective subtraction takes its sign from the mode
    assign sign_raw = (zero_raw && effective_subtraction) ? (rnd_mode == 3'b010) : sign;

    // Inactive lanes report nothing
    always_comb begin
        abs_rounded = '0;
        sign_res    = 1'b0;
        exact_zero  = 1'b0;
        inexact     = 1'b0;
        carry       = 1'b0;
        if (lane_en) begin
            abs_rounded = sum[AbsWidth-1:0];
            sign_res    = sign_raw;
            exact_zero  = zero_raw;
            inexact     = |round_sticky;
            carry       = sum[AbsWidth];
        end
    end
endmodule

module fpnew_rounding_pipe #(
    parameter int unsigned AbsWidth    = 8,
    parameter int unsigned NumLanes    = 4,
    parameter int unsigned NumPipeRegs = 1,
    parameter int unsigned TagWidth    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [TagWidth-1:0]          in_tag_i,
    input  logic [NumLanes*AbsWidth-1:0] abs_value_i,
    input  logic [NumLanes-1:0]          sign_i,
    input  logic [2*NumLanes-1:0]        round_sticky_bits_i,
    input  logic [2:0]                   rnd_mode_i,
    input  logic [NumLanes-1:0]          effective_subtraction_i,
    input  logic [NumLanes-1:0]          lane_mask_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [TagWidth-1:0]          out_tag_o,
    output logic [NumLanes*AbsWidth-1:0] abs_rounded_o,
    output logic [NumLanes-1:0]          sign_o,
    output logic [NumLanes-1:0]          exact_zero_o,
    output logic [NumLanes-1:0]          inexact_o,
    output logic [NumLanes-1:0]          carry_o,
    output logic [NumLanes-1:0]          out_mask_o,
    output logic                         busy_o
);
    localparam int unsigned VecW = NumLanes * AbsWidth;

    typedef struct packed {
        logic [TagWidth-1:0] tag;
        logic [VecW-1:0]     abs_rounded;
        logic [NumLanes-1:0] sign;
        logic [NumLanes-1:0] exact_zero;
        logic [NumLanes-1:0] inexact;
        logic [NumLanes-1:0] carry;
        logic [NumLanes-1:0] mask;
    } payload_t;

    logic [VecW-1:0]     lane_abs;
    logic [NumLanes-1:0] lane_sign;
    logic [NumLanes-1:0] lane_zero;
    logic [NumLanes-1:0] lane_inexact;
    logic [NumLanes-1:0] lane_carry;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        fpnew_rounding_lane #(
            .AbsWidth(AbsWidth)
        ) u_lane (
            .abs_value             (abs_value_i[k*AbsWidth +: AbsWidth]),
            .sign                  (sign_i[k]),
            .round_sticky          (round_sticky_bits_i[2*k +: 2]),
            .rnd_mode              (rnd_mode_i),
            .effective_subtraction (effective_subtraction_i[k]),
            .lane_en               (lane_mask_i[k]),
            .abs_rounded           (lane_abs[k*AbsWidth +: AbsWidth]),
            .sign_res              (lane_sign[k]),
            .exact_zero            (lane_zero[k]),
            .inexact               (lane_inexact[k]),
            .carry                 (lane_carry[k])
        );
    end

    // Element 0 of each chain is the combinational input side; element i+1
    // is the output of register stage i. en[i] is the load enable of stage i,
    // en[NumPipeRegs] is the downstream ready.
    logic     vld [NumPipeRegs+1];
    payload_t dat [NumPipeRegs+1];
    logic     en  [NumPipeRegs+1];

    assign vld[0]           = in_valid_i;
    assign dat[0]           = '{tag:         in_tag_i,
                                abs_rounded: lane_abs,
                                sign:        lane_sign,
                                exact_zero:  lane_zero,
                                inexact:     lane_inexact,
                                carry:       lane_carry,
                                mask:        lane_mask_i};
    assign en[NumPipeRegs]  = out_ready_i;

    for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
        logic     valid_q;
        payload_t data_q;

        // Stage register: loads when empty or draining, flush kills valid
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (en[i]) begin
                    valid_q <= vld[i];
                end
                if (en[i]) begin
                    data_q <= dat[i];
                end
            end
        end

        assign vld[i+1] = valid_q;
        assign dat[i+1] = data_q;
        assign en[i]    = ~valid_q | en[i+1];
    end

    assign in_ready_o    = en[0];
    assign out_valid_o   = vld[NumPipeRegs];
    assign out_tag_o     = dat[NumPipeRegs].tag;
    assign abs_rounded_o = dat[NumPipeRegs].abs_rounded;
    assign sign_o        = dat[NumPipeRegs].sign;
    assign exact_zero_o  = dat[NumPipeRegs].exact_zero;
    assign inexact_o     = dat[NumPipeRegs].inexact;
    assign carry_o       = dat[NumPipeRegs].carry;
    assign out_mask_o    = dat[NumPipeRegs].mask;

    // Busy whenever any register stage holds a live operation
    always_comb begin
        busy_o = 1'b0;
        for (int i = 1; i <= int'(NumPipeRegs); i++) begin
            busy_o = busy_o | vld[i];
        end
    end
endmodule

// File: doc/fpnew_rounding_pipe.md
# fpnew_rounding_pipe

Multi-lane, pipelined IEEE-754 rounding stage for the FPU datapath. It applies one rounding decision per lane to a packed vector of pre-rounded magnitudes. Each lane also reports inexact, carry-out, exact-zero and the final sign. Results move through a configurable number of valid/ready pipeline registers with a sideband tag, so SIMD-packed and cast units share one rounding back-end.

## Interface
- AbsWidth, 8: magnitude width per lane (≥2).
- NumLanes, 4: number of independent lanes (≥1).
- NumPipeRegs, 1: number of output register stages (≥0); 0 = combinational passthrough.
- TagWidth, 4: width of the opaque tag carried with each operation (≥1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous kill of all in-flight operations.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  input accepted when in_valid_i & in_ready_o.
- in_tag_i  in  TagWidth  tag, returned unchanged.
- abs_value_i  in  NumLanes*AbsWidth  lane magnitudes; lane k occupies bits [k*AbsWidth +: AbsWidth].
- sign_i  in  NumLanes  per-lane sign.
- round_sticky_bits_i  in  2*NumLanes  per-lane {round, sticky} at [2k+1:2k].
- rnd_mode_i  in  3  rounding mode, shared by all lanes.
- effective_subtraction_i  in  NumLanes  per-lane effective-subtraction flag.
- lane_mask_i  in  NumLanes  1 = lane active.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_tag_o  out  TagWidth  tag of the result.
- abs_rounded_o  out  NumLanes*AbsWidth  rounded magnitudes.
- sign_o, exact_zero_o, inexact_o, carry_o, out_mask_o  out  NumLanes each  per-lane result sign, exact zero, round/sticky nonzero, increment overflow, and registered lane_mask_i.
- busy_o  out  1  any pipeline stage holds a valid operation.

## Operation
- Rounding is evaluated combinationally at the input. The result is then registered through NumPipeRegs stages.
- Per-lane round_up, by rnd_mode_i:
  - 000 RNE: rs=00/01 → 0; rs=10 → abs[0]; rs=11 → 1.
  - 001 RTZ: 0.
  - 010 RDN: (|rs) & sign.
  - 011 RUP: (|rs) & ~sign.
  - 100 RMM: rs[1].
  - 101 ROD: ~abs[0] & (|rs).
  - 110/111 (reserved): 0, i.e. treated as RTZ.
- {carry, abs_rounded} = abs + round_up, computed AbsWidth+1 wide. An all-ones magnitude that rounds up wraps to 0 with carry=1.
- exact_zero = (abs==0) & (rs==00).
- sign_o = exact_zero & effective_subtraction ? (rnd_mode==010) : sign_i.
- inexact = |rs.
- Masked lanes (lane_mask_i=0) force abs_rounded, sign, exact_zero, inexact and carry to 0.
- Pipeline stage i register loads when its enable is high: en_i = ~valid_i | en_(i+1), with en_last = ~valid_last | out_ready_i.
- in_ready_o = en_0, combinational. If NumPipeRegs=0, in_ready_o = out_ready_i and out_valid_o = in_valid_i.
- Stalled stages hold data and valid unchanged. Order is strictly FIFO; there are no bubbles when out_ready_i stays high.
- flush_i clears every stage valid bit at the next edge. An input handshake in the same cycle is accepted but discarded. in_ready_o is not gated by flush_i.
- busy_o = OR of stage valid bits (0 when NumPipeRegs=0).

## Timing
- Latency is NumPipeRegs cycles from input handshake to out_valid_o. Throughput is 1 op/cycle.
- Reset, asynchronous: all valid bits, data, tag and mask registers go to 0. Therefore out_valid_o=0, busy_o=0 and all data outputs are 0. in_ready_o=1 while reset is asserted and after release.
- Reset asserted mid-operation drops all in-flight operations without producing output.
- A stage whose output is being consumed may accept new data in the same cycle (full pipelining); out_valid_o & out_ready_i & in_valid_i all high keeps occupancy constant.
- When all NumPipeRegs stages are full and out_ready_i=0, in_ready_o=0 in the same cycle.
- out_* are driven directly from the last register stage, with no combinational path from inputs, when NumPipeRegs≥1.

## Test plan
- RNE tie, AbsWidth=8, lane 0: abs=0x2A, rs=10 → 0x2A, inexact=1. abs=0x2B, rs=10 → 0x2C, carry=0.
- Directed modes, sign=1, abs=0x10, rs=01: RDN → 0x11; RUP → 0x10; RTZ → 0x10. ROD with abs=0x2A, rs=01 → 0x2B. Reserved mode 111 → 0x10.
- Overflow and zero: abs=0xFF, RUP, sign=0, rs=11 → abs_rounded=0x00, carry=1. abs=0, rs=00, effective_subtraction=1: RDN → sign_o=1, exact_zero=1; RNE → sign_o=0.
- Mask: lane_mask_i=4'b0101, all lanes abs=0xFF with RUP → lanes 1 and 3 output all zeros; lanes 0 and 2 report carry=1; out_mask_o=0101.
- Backpressure, NumPipeRegs=2: hold out_ready_i=0 and push tags 1, 2, 3 → tags 1 and 2 accepted, then in_ready_o=0. Release out_ready_i → tags 1, 2, 3 emerge in order on consecutive cycles with no loss or duplication.
- Flush and reset: with 2 ops in flight, assert flush_i for 1 cycle → out_valid_o=0 and busy_o=0 next cycle. Assert rst_i asynchronously mid-stream → outputs 0 immediately, in_ready_o=1.
